// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
// Holds per-digit hex values, scans anodes with a dwell counter, blanking guard and duty.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DWELL_W      = 17,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] dp_in,
  input  logic [7:0] digit_en,
  input  logic [3:0] brightness,
  output logic [7:0] anode,
  output logic [6:0] segments,
  output logic       dp,
  output logic [2:0] scan_idx,
  output logic       frame_tick
);

  localparam logic [DWELL_W-1:0] BlankLimit = DWELL_W'(BLANK_CYCLES);
  localparam logic [2:0]         LastIdx    = 3'(NUM_DIGITS - 1);

  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [2:0]         scan_q, scan_d;
  logic               frame_tick_q, frame_tick_d;
  logic [3:0]         digit_q [8];
  logic [3:0]         digit_d [8];
  logic [7:0]         anode_q, anode_d;
  logic [6:0]         segments_q, segments_d;
  logic               dp_q, dp_d;
  logic [3:0]         top4;
  logic               slot_on;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign top4 = dwell_q[DWELL_W-1 -: 4];

  always_comb begin
    dwell_d      = dwell_q + DWELL_W'(1);
    scan_d       = scan_q;
    frame_tick_d = 1'b0;
    if (&dwell_q) begin
      if (scan_q == LastIdx) begin
        scan_d       = 3'd0;
        frame_tick_d = 1'b1;
      end else begin
        scan_d = scan_q + 3'd1;
      end
    end

    for (int i = 0; i < 8; i++) digit_d[i] = digit_q[i];
    if (wr_en && (32'(wr_addr) < NUM_DIGITS)) digit_d[wr_addr] = wr_data;

    // Blank guard first, then duty window over the top bits of the dwell count
    slot_on    = (dwell_q >= BlankLimit) && (top4 < brightness) && digit_en[scan_q];
    anode_d    = 8'hFF;
    segments_d = 7'h7F;
    dp_d       = 1'b1;
    if (slot_on) begin
      anode_d    = ~(8'h01 << scan_q);
      segments_d = hex_to_seg(digit_q[scan_q]);
      dp_d       = ~dp_in[scan_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q      <= '0;
      scan_q       <= 3'd0;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < 8; i++) digit_q[i] <= 4'h0;
      anode_q      <= 8'hFF;
      segments_q   <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      dwell_q      <= dwell_d;
      scan_q       <= scan_d;
      frame_tick_q <= frame_tick_d;
      for (int i = 0; i < 8; i++) digit_q[i] <= digit_d[i];
      anode_q      <= anode_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
    end
  end

  assign anode      = anode_q;
  assign segments   = segments_q;
  assign dp         = dp_q;
  assign scan_idx   = scan_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl with a 64-cycle slot (DWELL_W=6, BLANK_CYCLES=4).
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic [7:0] dp_in = 8'h00;
  logic [7:0] digit_en = 8'hFF;
  logic [3:0] brightness = 4'hF;
  logic [7:0] anode;
  logic [6:0] segments;
  logic       dp;
  logic [2:0] scan_idx;
  logic       frame_tick;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (8),
    .DWELL_W     (6),
    .BLANK_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .brightness(brightness),
    .anode     (anode),
    .segments  (segments),
    .dp        (dp),
    .scan_idx  (scan_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [19:0] val;  // {anode, segments, dp, scan_idx, frame_tick}
  } exp_t;

  exp_t        sb[$];
  string       sb_name[$];
  int unsigned gcyc = 0;
  int unsigned base = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // Display values for digits 0..7 are 0,1,8,F,A,5,C,2
  logic [3:0] vals  [8] = '{4'h0, 4'h1, 4'h8, 4'hF, 4'hA, 4'h5, 4'hC, 4'h2};
  logic [6:0] seg_a [8] = '{7'h40, 7'h79, 7'h00, 7'h0E, 7'h08, 7'h12, 7'h46, 7'h24};

  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic logic [7:0] an_of(input int s);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << s);
  endfunction

  task automatic cmp(input string nm, input logic [19:0] act, input logic [19:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @k=%0d: got an=%h seg=%h dp=%b sc=%0d ft=%b, want an=%h seg=%h dp=%b sc=%0d ft=%b",
               nm, gcyc - base, act[19:12], act[11:5], act[4], act[3:1], act[0],
               req[19:12], req[11:5], req[4], req[3:1], req[0]);
    end
  endtask

  task automatic expect_at(input int unsigned k, input logic [7:0] an, input logic [6:0] seg,
                           input logic d, input int sc, input logic ft, input string nm);
    exp_t e;
    e.cyc = base + k;
    e.val = {an, seg, d, 3'(sc), ft};
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    while (sb.size() > 0 && sb[0].cyc <= gcyc) begin
      e  = sb.pop_front();
      nm = sb_name.pop_front();
      if (e.cyc < gcyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", nm, e.cyc, gcyc);
      end else begin
        cmp(nm, {anode, segments, dp, scan_idx, frame_tick}, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int unsigned k);
    while (gcyc - base < k) tick();
  endtask

  task automatic write_digit(input int a, input logic [3:0] v);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, %0d checks pending", sb.size());
    $fatal(1);
  end

  initial begin
    int k0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 cmp("reset_async", {anode, segments, dp, scan_idx, frame_tick}, {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    base  = gcyc;

    // Frame 0: brightness 15, on for dwell 4..59, visible one cycle later
    for (int s = 0; s < 8; s++) begin
      k0 = 64 * s;
      expect_at(k0 + 4,  8'hFF,    7'h7F,    1'b1, s, 1'b0, "a_blank");
      expect_at(k0 + 5,  an_of(s), seg_a[s], 1'b1, s, 1'b0, "a_on_first");
      expect_at(k0 + 60, an_of(s), seg_a[s], 1'b1, s, 1'b0, "a_on_last");
      expect_at(k0 + 61, 8'hFF,    7'h7F,    1'b1, s, 1'b0, "a_off");
    end
    expect_at(511, 8'hFF, 7'h7F, 1'b1, 7, 1'b0, "a_pre_wrap");
    expect_at(512, 8'hFF, 7'h7F, 1'b1, 0, 1'b1, "a_frame_tick");
    expect_at(513, 8'hFF, 7'h7F, 1'b1, 0, 1'b0, "a_tick_one_cycle");
    for (int i = 0; i < 8; i++) write_digit(i, vals[i]);

    // Frame 1: brightness 8 -> on for dwell 4..31
    run_to(512);
    brightness = 4'd8;
    for (int s = 0; s < 8; s++) begin
      k0 = 512 + 64 * s;
      expect_at(k0 + 5,  an_of(s), seg_a[s], 1'b1, s, 1'b0, "b8_on_first");
      expect_at(k0 + 32, an_of(s), seg_a[s], 1'b1, s, 1'b0, "b8_on_last");
      expect_at(k0 + 33, 8'hFF,    7'h7F,    1'b1, s, 1'b0, "b8_off");
    end

    // Frame 2: brightness 0 -> dark throughout
    run_to(1024);
    brightness = 4'd0;
    for (int s = 0; s < 8; s++) begin
      k0 = 1024 + 64 * s;
      expect_at(k0 + 5,  8'hFF, 7'h7F, 1'b1, s, 1'b0, "b0_dark_a");
      expect_at(k0 + 32, 8'hFF, 7'h7F, 1'b1, s, 1'b0, "b0_dark_b");
      expect_at(k0 + 60, 8'hFF, 7'h7F, 1'b1, s, 1'b0, "b0_dark_c");
    end

    // Frame 3: even slots disabled, scan keeps stepping, one tick per frame
    run_to(1536);
    brightness = 4'hF;
    digit_en   = 8'hAA;
    for (int s = 0; s < 8; s++) begin
      k0 = 1536 + 64 * s;
      expect_at(k0, 8'hFF, 7'h7F, 1'b1, s, (s == 0), "en_slot_edge");
      if (s % 2 == 1) begin
        expect_at(k0 + 5,  an_of(s), seg_a[s], 1'b1, s, 1'b0, "en_on_a");
        expect_at(k0 + 60, an_of(s), seg_a[s], 1'b1, s, 1'b0, "en_on_b");
      end else begin
        expect_at(k0 + 5,  8'hFF, 7'h7F, 1'b1, s, 1'b0, "en_dark_a");
        expect_at(k0 + 60, 8'hFF, 7'h7F, 1'b1, s, 1'b0, "en_dark_b");
      end
    end
    expect_at(2047, 8'hFF, 7'h7F, 1'b1, 7, 1'b0, "en_pre_wrap");
    expect_at(2048, 8'hFF, 7'h7F, 1'b1, 0, 1'b1, "en_frame_tick");
    expect_at(2049, 8'hFF, 7'h7F, 1'b1, 0, 1'b0, "en_tick_one_cycle");

    // Frame 4: live write into the shown digit, dp, write across a slot advance
    run_to(2048);
    digit_en = 8'hFF;
    dp_in    = 8'h08;
    expect_at(2181, 8'hFB, 7'h00, 1'b1, 2, 1'b0, "dp_other_slot");
    expect_at(2244, 8'hFF, 7'h7F, 1'b1, 3, 1'b0, "dp_blank");
    expect_at(2261, 8'hF7, 7'h0E, 1'b0, 3, 1'b0, "wr_old_value");
    expect_at(2262, 8'hF7, 7'h10, 1'b0, 3, 1'b0, "wr_new_value");
    expect_at(2301, 8'hFF, 7'h7F, 1'b1, 3, 1'b0, "dp_off_phase");
    expect_at(2309, 8'hEF, 7'h06, 1'b1, 4, 1'b0, "wr_at_advance");
    expect_at(2560, 8'hFF, 7'h7F, 1'b1, 0, 1'b1, "f4_frame_tick");
    expect_at(2565, 8'hFE, 7'h78, 1'b1, 0, 1'b0, "wr_digit0");
    run_to(2260);
    write_digit(3, 4'h9);
    run_to(2303);
    write_digit(4, 4'hE);
    run_to(2368);
    write_digit(0, 4'h7);

    // Reset in slot 5, then a clean restart from slot 0
    run_to(2890);
    #1 cmp("pre_reset_slot5", {anode, segments, dp, scan_idx, frame_tick},
           {8'hDF, 7'h12, 1'b1, 3'd5, 1'b0});
    #1 reset = 1'b1;
    #1 cmp("reset_mid_frame", {anode, segments, dp, scan_idx, frame_tick},
           {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    base  = gcyc;
    expect_at(5,   8'hFE, 7'h40, 1'b1, 0, 1'b0, "rst_digit0_cleared");
    expect_at(64,  8'hFF, 7'h7F, 1'b1, 1, 1'b0, "rst_no_tick_a");
    expect_at(69,  8'hFD, 7'h40, 1'b1, 1, 1'b0, "rst_digit1_cleared");
    expect_at(256, 8'hFF, 7'h7F, 1'b1, 4, 1'b0, "rst_no_tick_b");
    expect_at(511, 8'hFF, 7'h7F, 1'b1, 7, 1'b0, "rst_no_tick_c");
    expect_at(512, 8'hFF, 7'h7F, 1'b1, 0, 1'b1, "rst_first_tick");
    run_to(515);
    tick();

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending checks, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. Holds a per-digit hex value register file written by the core/MMIO side. Sequences the anode scan with a dwell counter, and applies an inter-digit blanking guard and a 4-bit brightness duty. Drives the display pins from registers, sitting between the memory-mapped display write port and the FPGA I/O.

Parameters:
NUM_DIGITS, 8, number of scanned digits (1..8); anode bits >= NUM_DIGITS held high
DWELL_W, 17, dwell counter width; each digit slot lasts 2^DWELL_W cycles (must be >= 4)
BLANK_CYCLES, 16, cycles at slot start with all anodes off (anti-ghosting); must be < 2^DWELL_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe for digit register file
wr_addr  in  3  digit index to write (writes with wr_addr >= NUM_DIGITS ignored)
wr_data  in  4  hex value for digit
dp_in  in  8  decimal point request per digit (1 = lit)
digit_en  in  8  per-digit enable (0 = slot dark but still scanned)
brightness  in  4  duty level, 0 = off, 15 = 15/16 of post-blank window
anode  out  8  active-low digit selects, registered
segments  out  7  active-low {g,f,e,d,c,b,a}, registered
dp  out  1  active-low decimal point, registered
scan_idx  out  3  current digit slot (counter value, not delayed)
frame_tick  out  1  one-cycle pulse when scan_idx wraps NUM_DIGITS-1 -> 0

Behaviour:
- Reset (async, immediate, no clock needed): dwell_cnt=0, scan_idx=0, digit regs all 0, anode=8'hFF, segments=7'h7F, dp=1, frame_tick=0.
- Digit regs: on wr_en, reg[wr_addr] <= wr_data at the clock edge; visible to the decode path from the next cycle.
- dwell_cnt increments every cycle and wraps naturally. When dwell_cnt == all-ones, scan_idx advances the next cycle: +1, or wraps NUM_DIGITS-1 -> 0.
- frame_tick is registered and high for exactly the cycle in which scan_idx becomes 0 via wrap. It never fires out of reset.
- Slot phases, a function of dwell_cnt with top4 = dwell_cnt[DWELL_W-1:DWELL_W-4]:
  BLANK: dwell_cnt < BLANK_CYCLES -> no anode.
  ON: dwell_cnt >= BLANK_CYCLES and top4 < brightness and digit_en[scan_idx] -> anode[scan_idx] low.
  OFF: any other case -> no anode.
- Output register: anode/segments/dp take the phase computed from dwell_cnt/scan_idx in cycle N at the edge ending cycle N. Output latency is 1 cycle.
- While no anode is active, segments are forced to 7'h7F and dp to 1. Segment lines never show stale data while dark.
- Decode is active-low hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- dp = ~dp_in[scan_idx] when ON.
- Write to the digit currently displayed: new pattern appears on segments 2 cycles after the wr_en cycle. A simultaneous slot advance does not corrupt the value.
- brightness, digit_en and dp_in are sampled live each cycle. A change mid-slot takes effect next output cycle.
- Reset mid-frame: everything returns to reset values at once, and scanning restarts at slot 0.

Test Plan:
1. DWELL_W=6, BLANK_CYCLES=4, all enables on, brightness=15. Assert reset mid-cycle -> anode=FF, segments=7F, dp=1, scan_idx=0 before any clock edge.
2. Write digits 0..7 = 0,1,8,F,A,5,C,2, then release. Slot k: anode=~(1<<k) for 56 cycles (cnt 4..59, +1 latency), with segments 40,79,00,0E,08,12,46,24 respectively. Otherwise anode=FF and segments=7F.
3. brightness=8 -> 28 ON cycles per slot (cnt 4..31). brightness=0 -> anode stays FF for a full frame.
4. digit_en=8'hAA -> slots 0,2,4,6 dark while scan_idx still steps every 64 cycles. frame_tick pulses exactly once per 512 cycles.
5. Slot 3 at cnt=20: write wr_addr=3, wr_data=9 -> segments change from 0E to 10 exactly 2 cycles later. dp_in[3]=1 -> dp=0 during ON only.
6. Reset asserted at scan_idx=5 -> immediate reset outputs. After release, slot 0 shows 40 (cleared reg). frame_tick stays 0 until the first full wrap.
